imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the CPU instruction memory.
- Receives a framed byte stream (one byte per `in_valid` pulse, e.g. from the UART receiver), packs bytes into 32-bit big-endian instruction words and issues one-cycle write strobes into the instruction memory write port.
- Holds the CPU pipeline while a program is loading and reports completion or error.

Parameters:
- ADDR_W, 8, word-address width; memory depth = 2**ADDR_W words (256).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, max idle clocks between bytes inside a frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  single-cycle strobe, in_data valid; always accepted (no back-pressure).
- in_data  input  8  received byte.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  ADDR_W  word index being written.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  high while loading and after a failed load.
- done  output  1  one-cycle pulse, frame loaded and checksum good.
- err  output  1  one-cycle pulse on frame error.
- err_code  output  2  registered cause of last error: 0 none, 1 length>depth, 2 checksum, 3 timeout.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; word index, byte count, checksum and timeout counter cleared. Applies mid-frame; the partial program stays in memory, with no cleanup writes.
- Frame: SYNC_BYTE, LEN_HI, LEN_LO (N = 16-bit word count), 4*N data bytes (MSB first per word), CKSUM = XOR of all 4*N data bytes.
- States and transitions:
  - IDLE: a byte equal to SYNC_BYTE moves to LEN_HI and sets cpu_hold=1. Any other byte is ignored.
  - LEN_HI: on a byte, go to LEN_LO.
  - LEN_LO: on a byte, test N:
    - N > 2**ADDR_W: err pulse, err_code=1, back to IDLE.
    - N = 0: go to CKSUM.
    - Otherwise: go to DATA with index=0, checksum=0.
  - DATA: each byte shifts into the word and XORs into the checksum.
    - On the 4th byte, the cycle after acceptance has imem_we=1, imem_addr=index and imem_wdata={b0,b1,b2,b3}. Then index increments.
    - After word N-1, go to CKSUM.
  - CKSUM: on a byte, compare with the running checksum.
    - Match: done pulse next cycle, err_code=0, cpu_hold=0, go to IDLE.
    - Mismatch: err pulse, err_code=2, go to IDLE.
- cpu_hold: set on sync accept. Cleared only by done or reset; it stays high after any error.
- Timeout counter:
  - Reloads on every accepted byte and counts clocks in LEN_HI, LEN_LO, DATA and CKSUM.
  - When it reaches TIMEOUT_CYCLES: err pulse, err_code=3, back to IDLE.
  - A byte arriving in the same cycle as expiry is accepted and the timeout is suppressed.
- Limits: maximum N = 2**ADDR_W; index never wraps. A SYNC_BYTE value inside the payload is plain data.
- imem_we is never asserted for two consecutive cycles; the minimum spacing is 4 bytes.

Decomposition:
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CKSUM);
  - err_code constants (ERR_NONE, ERR_LEN, ERR_CKSUM, ERR_TIMEOUT);
  - default SYNC_BYTE.
- One sub-module, `imem_word_pack`: 4-byte shift register with byte counter, emitting a word-valid pulse plus the packed word.

Test Plan:
- A5 00 01 34 08 00 20 1C -> one write, addr 0, data 32'h34080020; done pulse; cpu_hold falls; err_code 0.
- A5 00 02, words 34080020 and 34090030, cksum 11 -> writes at addr 0 then 1; done.
- A5 01 01 -> err pulse, err_code 1, no writes, cpu_hold stays 1.
- A5 00 01 34 08 00 20 FF -> write at addr 0 occurs, then err_code 2, no done, cpu_hold stays 1.
- A5 00, then TIMEOUT_CYCLES idle clocks -> err, err_code 3. A following valid frame loads and clears cpu_hold.
- Assert rst mid-DATA, then deassert -> all outputs 0. Stray bytes 00 FF are ignored; a valid frame then loads correctly from addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Holds FSM states, error cause codes and the default frame sync byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CKSUM   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, memory write port and status lines of the loader.
// The byte stream has no back-pressure: in_valid is a one-cycle strobe and is always accepted.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  state_t            dbg_state;

  modport master (
    input  in_valid, in_data,
    output imem_we, imem_addr, imem_wdata, cpu_hold, done, err, err_code, dbg_state
  );

  modport slave (
    output in_valid, in_data,
    input  imem_we, imem_addr, imem_wdata, cpu_hold, done, err, err_code, dbg_state
  );
endinterface

// File: rtl/imem_loader_word_pack.sv
// Big-endian 4-byte packer: the first byte lands in bits [31:24].
// o_word_valid is combinational and flags the acceptance cycle of the 4th byte.
module imem_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);
  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_valid) begin
      r_shift <= {r_shift[15:0], i_data};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word_valid = i_valid && (r_cnt == 2'd3);
  assign o_word       = {r_shift, i_data};
endmodule

// File: rtl/imem_loader.sv
// Frame parser that loads a program into instruction memory and holds the CPU meanwhile.
// Frame: SYNC, LEN_HI, LEN_LO, 4*N data bytes, XOR checksum of the data bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W         = 8,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic           clk,
  input logic           rst,
  imem_loader_if.master bus
);
  localparam int          TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            r_state, w_state_n;
  logic [TMO_W-1:0]  r_tmo;
  logic [7:0]        r_len_hi;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_index;
  logic [7:0]        r_cksum;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_hold;

  logic              w_err;
  logic [1:0]        w_err_code;
  logic              w_done;
  logic              w_hold_set;
  logic              w_start;
  logic              w_tmo_hit;
  logic              w_pack_valid;
  logic              w_word_valid;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic              w_last_word;

  assign w_len        = {r_len_hi, bus.in_data};
  assign w_last_word  = (r_index + {{ADDR_W{1'b0}}, 1'b1}) == r_len;
  assign w_pack_valid = bus.in_valid && (r_state == ST_DATA);
  // A byte in the expiry cycle wins: expiry only fires on a byte-less cycle.
  assign w_tmo_hit    = (r_state != ST_IDLE) && !bus.in_valid &&
                        (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  imem_word_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start),
    .i_valid      (w_pack_valid),
    .i_data       (bus.in_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_err      = 1'b0;
    w_err_code = r_err_code;
    w_done     = 1'b0;
    w_hold_set = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_data == SYNC_BYTE) begin
          w_state_n  = ST_LEN_HI;
          w_hold_set = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (bus.in_valid) w_state_n = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (bus.in_valid) begin
          w_start = 1'b1;
          if ({1'b0, w_len} > DEPTH) begin
            w_state_n  = ST_IDLE;
            w_err      = 1'b1;
            w_err_code = ERR_LEN;
          end else if (w_len == 16'd0) begin
            w_state_n = ST_CKSUM;
          end else begin
            w_state_n = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_word_valid && w_last_word) w_state_n = ST_CKSUM;
      end
      ST_CKSUM: begin
        if (bus.in_valid) begin
          w_state_n = ST_IDLE;
          if (bus.in_data == r_cksum) begin
            w_done     = 1'b1;
            w_err_code = ERR_NONE;
          end else begin
            w_err      = 1'b1;
            w_err_code = ERR_CKSUM;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
    if (w_tmo_hit) begin
      w_state_n  = ST_IDLE;
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo      <= '0;
      r_len_hi   <= '0;
      r_len      <= '0;
      r_index    <= '0;
      r_cksum    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_hold     <= 1'b0;
    end else begin
      r_we       <= 1'b0;
      r_done     <= w_done;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      if (w_hold_set)  r_hold <= 1'b1;
      else if (w_done) r_hold <= 1'b0;

      if (r_state == ST_IDLE || bus.in_valid || w_tmo_hit) r_tmo <= '0;
      else                                                 r_tmo <= r_tmo + 1'b1;

      if (r_state == ST_LEN_HI && bus.in_valid) r_len_hi <= bus.in_data;
      if (w_start) begin
        r_len   <= w_len[ADDR_W:0];
        r_index <= '0;
        r_cksum <= '0;
      end
      if (w_pack_valid) begin
        r_cksum <= r_cksum ^ bus.in_data;
        if (w_word_valid) begin
          r_we    <= 1'b1;
          r_addr  <= r_index[ADDR_W-1:0];
          r_wdata <= w_word;
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_hold   = r_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: stimulus pushes expected events, a negedge monitor pops and compares.
// Event word: {kind[1:0], err_code[1:0], addr[7:0], data[31:0]}; kind 0 write, 1 done, 2 err.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int TMO = 40;
  localparam int W   = 44;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic prev_we;
  logic [W-1:0] exp_q[$];

  imem_loader_if #(.ADDR_W(8)) bus();

  imem_loader #(
    .ADDR_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ev_wr(input logic [7:0] a, input logic [31:0] d);
    return {2'd0, 2'd0, a, d};
  endfunction
  function automatic logic [W-1:0] ev_done();
    return {2'd1, 2'd0, 8'd0, 32'd0};
  endfunction
  // err events also carry cpu_hold, which must still be high after any error
  function automatic logic [W-1:0] ev_err(input logic [1:0] c);
    return {2'd2, c, 8'd0, 32'd1};
  endfunction

  // monitor / scoreboard
  initial prev_we = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (rst) begin
      if (prev_we && bus.imem_we) begin
        total++; bad++;
        $display("FAIL we_back_to_back: imem_we high two cycles in a row");
      end
      prev_we = bus.imem_we;
      if (bus.imem_we || bus.done || bus.err) begin
        if (bus.imem_we)   obs = {2'd0, 2'd0, bus.imem_addr, bus.imem_wdata};
        else if (bus.done) obs = {2'd1, bus.err_code, 8'd0, 31'd0, bus.cpu_hold};
        else               obs = {2'd2, bus.err_code, 8'd0, 31'd0, bus.cpu_hold};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got %h, expected nothing", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL event: got %h, expected %h", obs, e);
          end
        end
      end
    end else begin
      prev_we = 1'b0;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_outputs(input string name, input logic [45:0] want);
    logic [45:0] got;
    #1;
    got = {bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.cpu_hold,
           bus.done, bus.err, bus.err_code};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic check_hold(input string name, input logic want);
    total++;
    if (bus.cpu_hold !== want) begin
      bad++;
      $display("FAIL %s: cpu_hold=%b expected %b", name, bus.cpu_hold, want);
    end
  endtask

  task automatic frame_one_word();
    logic [7:0] f[$];
    f = '{8'hA5, 8'h00, 8'h01, 8'h34, 8'h08, 8'h00, 8'h20, 8'h1C};
    exp_q.push_back(ev_wr(8'd0, 32'h34080020));
    exp_q.push_back(ev_done());
    foreach (f[i]) send_byte(f[i]);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] ck;
    logic [7:0] iv;
    logic [31:0] wd;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_outputs("reset_state", 46'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single word, checksum 1C
    frame_one_word();
    wait_drain(20, "one_word");
    check_hold("one_word_hold", 1'b0);

    // two words, checksum 11
    f = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h20,
          8'h34, 8'h09, 8'h00, 8'h30, 8'h11};
    exp_q.push_back(ev_wr(8'd0, 32'h34080020));
    exp_q.push_back(ev_wr(8'd1, 32'h34090030));
    exp_q.push_back(ev_done());
    foreach (f[i]) send_byte(f[i]);
    wait_drain(20, "two_words");

    // N = 257 exceeds depth
    f = '{8'hA5, 8'h01, 8'h01};
    exp_q.push_back(ev_err(ERR_LEN));
    foreach (f[i]) send_byte(f[i]);
    wait_drain(20, "len_err");
    check_hold("len_err_hold", 1'b1);

    // bad checksum after a good write
    f = '{8'hA5, 8'h00, 8'h01, 8'h34, 8'h08, 8'h00, 8'h20, 8'hFF};
    exp_q.push_back(ev_wr(8'd0, 32'h34080020));
    exp_q.push_back(ev_err(ERR_CKSUM));
    foreach (f[i]) send_byte(f[i]);
    wait_drain(20, "cksum_err");

    // stall inside the length field
    exp_q.push_back(ev_err(ERR_TIMEOUT));
    send_byte(8'hA5);
    send_byte(8'h00);
    wait_drain(TMO + 10, "timeout");
    check_hold("timeout_hold", 1'b1);
    frame_one_word();
    wait_drain(20, "after_timeout");
    check_hold("after_timeout_hold", 1'b0);

    // zero-length frame: checksum of nothing is 00
    f = '{8'hA5, 8'h00, 8'h00, 8'h00};
    exp_q.push_back(ev_done());
    foreach (f[i]) send_byte(f[i]);
    wait_drain(20, "zero_len");

    // full depth, payload includes the sync value as plain data
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    ck = 8'h00;
    for (int i = 0; i < 256; i++) begin
      iv = 8'(i);
      wd = {iv, ~iv, 8'hA5, iv ^ 8'h3C};
      exp_q.push_back(ev_wr(iv, wd));
      for (int k = 3; k >= 0; k--) begin
        ck = ck ^ wd[k*8 +: 8];
        send_byte(wd[k*8 +: 8]);
      end
    end
    exp_q.push_back(ev_done());
    send_byte(ck);
    wait_drain(20, "full_depth");

    // reset in the middle of DATA
    f = '{8'hA5, 8'h00, 8'h02, 8'h34, 8'h08};
    foreach (f[i]) send_byte(f[i]);
    @(negedge clk);
    rst = 1'b0;
    check_outputs("mid_reset", 46'd0);
    @(negedge clk);
    rst = 1'b1;
    check_outputs("after_reset", 46'd0);
    send_byte(8'h00);
    send_byte(8'hFF);
    repeat (5) @(negedge clk);
    check_outputs("stray_ignored", 46'd0);
    frame_one_word();
    wait_drain(20, "after_reset_frame");
    check_hold("after_reset_hold", 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: %0d events pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
